uart_receiver: RTL and testbench

Serial-to-parallel receiver for the one-bit-per-clock UART frame produced by the team's transmitter (`UART_T`). It watches the serial line `rx` every clock edge and deframes each frame: start bit 0, then `d_width` data bits LSB first, then stop bit 1. Each good frame is delivered as a parallel word through a one-entry valid/ready holding stage. Framing errors and overruns are flagged. It sits at the receive end of the link, with `rx` driven by the transmitter's `tx`.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_hold.sv | 42 ++++
 rtl/uart_receiver.sv | 89 ++++++++
 tb/tb_uart_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry defaults, receiver states and line levels.
package uart_pkg;

    localparam int D_WIDTH = 16;
    localparam int C_WIDTH = 5;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        DATA      = 2'd2,
        STOP      = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_hold.sv
// One-entry valid/ready holding register for received words, with overrun flag.
module uart_rx_hold
    import uart_pkg::*;
#(
    parameter int d_width = D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [d_width-1:0] load_data,
    input  logic               rx_ready,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_ovr
);

    logic drain;
    logic room;

    assign drain = rx_valid && rx_ready;
    // A word may load into an empty stage or one that is handing off this edge
    assign room  = !rx_valid || rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_ovr <= 1'b0;
            if (load && room) begin
                rx_data  <= load_data;
                rx_valid <= 1'b1;
            end else if (load) begin
                rx_ovr <= 1'b1;
            end else if (drain) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// One-sample-per-clock UART deframer: start, d_width data bits LSB first, stop.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int d_width = D_WIDTH,
    parameter int c_width = C_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_ferr,
    output logic               rx_ovr
);

    localparam logic [c_width-1:0] LAST_BIT = c_width'(d_width - 1);

    rx_state_t          state, state_nxt;
    logic [c_width-1:0] cnt, cnt_nxt;
    logic [d_width-1:0] shreg, shreg_nxt;
    logic               good_stop;
    logic               bad_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_HIGH;
            cnt     <= '0;
            shreg   <= '0;
            rx_busy <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            rx_busy <= (state_nxt == DATA) || (state_nxt == STOP);
            rx_ferr <= bad_stop;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            // A line held low out of reset must go high before a start is trusted
            WAIT_HIGH: if (rx == STOP_BIT) state_nxt = IDLE;
            IDLE: begin
                if (rx == START_BIT) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                shreg_nxt = {rx, shreg[d_width-1:1]};
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST_BIT) state_nxt = STOP;
            end
            STOP: begin
                if (rx == STOP_BIT) begin
                    good_stop = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    bad_stop  = 1'b1;
                    state_nxt = WAIT_HIGH;
                end
            end
            default: state_nxt = WAIT_HIGH;
        endcase
    end

    uart_rx_hold #(
        .d_width (d_width)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (good_stop),
        .load_data (shreg),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ovr    (rx_ovr)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: framing, handshake, errors, reset.
module tb_uart_receiver;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        rx_ferr;
    logic        rx_ovr;

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic clr_cnt = 1'b0;

    uart_receiver #(.d_width(16), .c_width(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .rx_ferr  (rx_ferr),
        .rx_ovr   (rx_ovr)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; cleared by request from the test tasks
    always @(negedge clk) begin
        if (clr_cnt) begin
            ferr_cnt = 0;
            ovr_cnt  = 0;
        end else begin
            if (rx_ferr) ferr_cnt++;
            if (rx_ovr)  ovr_cnt++;
        end
    end

    task automatic clear_counts();
        clr_cnt = 1'b1;
        @(negedge clk);
        #1 clr_cnt = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        @(posedge clk);
        #1;
        if (rx_busy) busy_cnt++;
    endtask

    task automatic send_data(input logic [15:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 16; i++) send_bit(d[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b0; rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 16'h0 || rx_valid !== 1'b0 || rx_busy !== 1'b0 || rx_ferr !== 1'b0 || rx_ovr !== 1'b0) begin
            $display("FAIL reset_outputs: data=%h v=%b b=%b f=%b o=%b want all 0", rx_data, rx_valid, rx_busy, rx_ferr, rx_ovr);
            errors++;
        end
        rst = 1'b0;
        busy_cnt = 0;
        repeat (5) send_bit(1'b0);
        checks++;
        if (busy_cnt !== 0) begin
            $display("FAIL low_after_reset: busy cycles=%0d want 0", busy_cnt);
            errors++;
        end
        send_bit(1'b1);
        busy_cnt = 0;
        send_data(16'hA5C3);
        send_bit(1'b1);
        checks++;
        if (rx_data !== 16'hA5C3 || rx_valid !== 1'b1) begin
            $display("FAIL first_frame: data=%h v=%b want a5c3 1", rx_data, rx_valid);
            errors++;
        end
        checks++;
        if (busy_cnt !== 17) begin
            $display("FAIL busy_length: got %0d want 17", busy_cnt);
            errors++;
        end
        rx_ready = 1'b1;
        send_bit(1'b1);
        checks++;
        if (rx_valid !== 1'b0) begin
            $display("FAIL drain: valid=%b want 0", rx_valid);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b1;
        clear_counts();
        send_data(16'h0001);
        send_bit(1'b1);
        checks++;
        if (rx_data !== 16'h0001 || rx_valid !== 1'b1) begin
            $display("FAIL b2b_word0: data=%h v=%b want 0001 1", rx_data, rx_valid);
            errors++;
        end
        send_bit(1'b0);
        checks++;
        if (rx_valid !== 1'b0 || rx_busy !== 1'b1) begin
            $display("FAIL b2b_restart: v=%b busy=%b want 0 1", rx_valid, rx_busy);
            errors++;
        end
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if (rx_data !== 16'hFFFF || rx_valid !== 1'b1) begin
            $display("FAIL b2b_word1: data=%h v=%b want ffff 1", rx_data, rx_valid);
            errors++;
        end
        send_bit(1'b1);
        checks++;
        if (ferr_cnt !== 0 || ovr_cnt !== 0) begin
            $display("FAIL b2b_errors: ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt);
            errors++;
        end
    endtask

    task automatic test_framing_error();
        rx_ready = 1'b1;
        send_bit(1'b1);
        clear_counts();
        send_data(16'h1234);
        send_bit(1'b0);
        checks++;
        if (rx_ferr !== 1'b1 || rx_valid !== 1'b0) begin
            $display("FAIL ferr_pulse: ferr=%b v=%b want 1 0", rx_ferr, rx_valid);
            errors++;
        end
        busy_cnt = 0;
        repeat (3) send_bit(1'b0);
        checks++;
        if (ferr_cnt !== 1 || busy_cnt !== 0 || rx_valid !== 1'b0) begin
            $display("FAIL ferr_recover: ferr=%0d busy=%0d v=%b want 1 0 0", ferr_cnt, busy_cnt, rx_valid);
            errors++;
        end
        send_bit(1'b1);
        send_data(16'h5678);
        send_bit(1'b1);
        checks++;
        if (rx_data !== 16'h5678 || rx_valid !== 1'b1) begin
            $display("FAIL after_ferr: data=%h v=%b want 5678 1", rx_data, rx_valid);
            errors++;
        end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b1;
        send_bit(1'b1);
        rx_ready = 1'b0;
        clear_counts();
        send_data(16'h1111);
        send_bit(1'b1);
        send_data(16'h2222);
        send_bit(1'b1);
        checks++;
        if (rx_ovr !== 1'b1 || rx_data !== 16'h1111 || rx_valid !== 1'b1) begin
            $display("FAIL overrun: ovr=%b data=%h v=%b want 1 1111 1", rx_ovr, rx_data, rx_valid);
            errors++;
        end
        send_bit(1'b1);
        checks++;
        if (ovr_cnt !== 1 || ferr_cnt !== 0) begin
            $display("FAIL ovr_single: ovr=%0d ferr=%0d want 1 0", ovr_cnt, ferr_cnt);
            errors++;
        end
    endtask

    task automatic test_drain_and_load();
        clear_counts();
        send_data(16'h2222);
        rx_ready = 1'b1;
        send_bit(1'b1);
        rx_ready = 1'b0;
        checks++;
        if (rx_data !== 16'h2222 || rx_valid !== 1'b1 || rx_ovr !== 1'b0) begin
            $display("FAIL drain_load: data=%h v=%b ovr=%b want 2222 1 0", rx_data, rx_valid, rx_ovr);
            errors++;
        end
        send_bit(1'b1);
        checks++;
        if (ovr_cnt !== 0 || rx_valid !== 1'b1) begin
            $display("FAIL drain_load_hold: ovr=%0d v=%b want 0 1", ovr_cnt, rx_valid);
            errors++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        d = 16'hFF00;
        rx_ready = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rst = 1'b1;
        send_bit(d[8]);
        rst = 1'b0;
        checks++;
        if (rx_data !== 16'h0 || rx_valid !== 1'b0 || rx_busy !== 1'b0 || rx_ferr !== 1'b0 || rx_ovr !== 1'b0) begin
            $display("FAIL mid_reset_outputs: data=%h v=%b b=%b f=%b o=%b want all 0", rx_data, rx_valid, rx_busy, rx_ferr, rx_ovr);
            errors++;
        end
        checks++;
        if (dut.state !== WAIT_HIGH) begin
            $display("FAIL mid_reset_state: got %0d want %0d", dut.state, WAIT_HIGH);
            errors++;
        end
        clear_counts();
        busy_cnt = 0;
        for (int i = 9; i < 16; i++) send_bit(d[i]);
        repeat (4) send_bit(1'b1);
        checks++;
        if (busy_cnt !== 0 || rx_valid !== 1'b0 || ferr_cnt !== 0 || ovr_cnt !== 0) begin
            $display("FAIL mid_reset_tail: busy=%0d v=%b ferr=%0d ovr=%0d want 0 0 0 0", busy_cnt, rx_valid, ferr_cnt, ovr_cnt);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_framing_error();
        test_overrun();
        test_drain_and_load();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
